// File: rtl/sys_array_pkg.sv
// Shared definitions for the systolic-array output collector.
package sys_array_pkg;

  // Width of the saturating dropped-row counter.
  localparam int DROP_CNT_W = 16;

  // Mesh column that owns a given output lane.
  function automatic int lane_to_col(input int lane, input int tile_columns);
    return lane / tile_columns;
  endfunction

endpackage

// File: rtl/sys_array_collector_if.sv
// Row output bus of the collector.
// Handshake: a row transfers on every rising clock edge where out_valid and
// out_ready are both high. While out_valid is high, out_data and out_last stay
// stable until the transfer; out_valid never depends on out_ready.
interface sys_array_collector_if #(
  parameter int N        = 4,
  parameter int BITWIDTH = 16
);
  logic [N*BITWIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/row_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is legal when a pop
// happens in the same cycle (the freed slot is the one being written).
module row_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero when empty so the bus reads 0 out of reset.
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra wrap bit separates full from empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/sys_array_collector.sv
// De-skews the column-staggered mesh result stream into aligned rows, buffers
// them in a FIFO and tags the last row of each matrix. Faults are counted and
// flagged; the mesh is never stalled.
module sys_array_collector
  import sys_array_pkg::*;
#(
  parameter int MESHCOLUMNS = 4,
  parameter int TILECOLUMNS = 1,
  parameter int BITWIDTH    = 16,
  parameter int DEPTH       = 8,
  parameter int ROWCNTW     = 8
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic [MESHCOLUMNS*TILECOLUMNS*BITWIDTH-1:0] in_c,
  input  logic [MESHCOLUMNS*TILECOLUMNS-1:0]          in_valid,
  input  logic [ROWCNTW-1:0]                          cfg_rows,
  input  logic                                        clear_flags,
  sys_array_collector_if.master                       bus,
  output logic                                        overflow,
  output logic                                        skew_err,
  output logic [DROP_CNT_W-1:0]                       drop_cnt
);
  localparam int N = MESHCOLUMNS * TILECOLUMNS;

  typedef struct packed {
    logic [N*BITWIDTH-1:0] data;
    logic                  last;
  } row_t;

  logic [N*BITWIDTH-1:0] al_data;
  logic [N-1:0]          al_valid;

  // Lanes of mesh column m wait MESHCOLUMNS-1-m cycles so every lane of a
  // row lines up with the last column.
  for (genvar n = 0; n < N; n++) begin : g_lane
    localparam int STAGES = MESHCOLUMNS - 1 - lane_to_col(n, TILECOLUMNS);
    if (STAGES == 0) begin : g_thru
      assign al_data[n*BITWIDTH +: BITWIDTH] = in_c[n*BITWIDTH +: BITWIDTH];
      assign al_valid[n] = in_valid[n];
    end else begin : g_dly
      logic [BITWIDTH-1:0] d_pipe [STAGES];
      logic [STAGES-1:0]   v_pipe;

      // Valid shift chain; cleared on reset so rows in flight vanish cleanly.
      always_ff @(posedge clock) begin
        if (reset) begin
          v_pipe <= '0;
        end else begin
          v_pipe[0] <= in_valid[n];
          for (int s = 1; s < STAGES; s++) v_pipe[s] <= v_pipe[s-1];
        end
      end

      // Data shift chain; qualified by the valid chain, so no reset.
      always_ff @(posedge clock) begin
        d_pipe[0] <= in_c[n*BITWIDTH +: BITWIDTH];
        for (int s = 1; s < STAGES; s++) d_pipe[s] <= d_pipe[s-1];
      end

      assign al_data[n*BITWIDTH +: BITWIDTH] = d_pipe[STAGES-1];
      assign al_valid[n] = v_pipe[STAGES-1];
    end
  end

  logic cand, mixed, pop, push, ovf_drop, full, empty;
  row_t wr_row, head;

  assign cand     = &al_valid;
  assign mixed    = (|al_valid) && !cand;
  assign pop      = !empty && bus.out_ready;
  assign push     = cand && (!full || pop);
  assign ovf_drop = cand && full && !pop;

  logic [ROWCNTW-1:0] rc, lim_q, lim_eff;
  logic               row_last;

  // Row limit is taken from cfg_rows only when a matrix starts (rc == 0).
  always_comb begin
    lim_eff = lim_q;
    if (rc == '0) lim_eff = (cfg_rows == '0) ? ROWCNTW'(1) : cfg_rows;
    row_last = (rc == lim_eff - ROWCNTW'(1));
  end

  // Row counter advances only on rows actually written to the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      rc    <= '0;
      lim_q <= ROWCNTW'(1);
    end else if (push) begin
      lim_q <= lim_eff;
      rc    <= row_last ? '0 : rc + ROWCNTW'(1);
    end
  end

  // Sticky fault flags and saturating drop count; a fault beats a clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
      skew_err <= 1'b0;
      drop_cnt <= '0;
    end else if (clear_flags) begin
      overflow <= ovf_drop;
      skew_err <= mixed;
      drop_cnt <= (ovf_drop || mixed) ? DROP_CNT_W'(1) : '0;
    end else begin
      if (ovf_drop) overflow <= 1'b1;
      if (mixed)    skew_err <= 1'b1;
      if ((ovf_drop || mixed) && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign wr_row = '{data: al_data, last: row_last};

  row_fifo #(.WIDTH($bits(row_t)), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_row),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.out_valid = !empty;
  assign bus.out_data  = head.data;
  assign bus.out_last  = head.last;
endmodule
